fir_seq_param: RTL and testbench
================================

# fir_seq_param

Parametrised, time-multiplexed signed FIR filter: one multiplier and one accumulator evaluate all TAPS products serially, one tap per clock. Coefficients are run-time loadable through a write port. The output is rounded and saturated to the input width. It sits between a sample source and sink that use an `act`/`ready` input handshake and a one-cycle `y_valid` output strobe. It is the generalised successor of the fixed 11-tap, fixed-coefficient sequential FIR.

## Interface
- `DW`, 16: sample width. Signed two's complement.
- `CW`, 16: coefficient width. Signed two's complement.
- `TAPS`, 11: number of taps, at least 2.
- `AW`, 4: coefficient address width, with 2^AW ≥ TAPS.
- `ACCW`, 40: accumulator width, with ACCW ≥ DW+CW+clog2(TAPS).
- `OSHIFT`, 15: right shift applied to the accumulator before output, at least 1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_p` input 1: reset, synchronous and active-high.
- `x` input DW: input sample, signed.
- `act` input 1: sample valid. Accepted on an edge where `act` and `ready` are both 1.
- `ready` output 1: block idle and able to accept a sample.
- `y` output DW: filtered output, signed. Held between results.
- `y_valid` output 1: one-cycle pulse marking a new `y`.
- `coef_we` input 1: coefficient write enable.
- `coef_addr` input AW: coefficient index; 0 multiplies the newest sample.
- `coef_wdata` input CW: coefficient value, signed.

## Operation
- Storage:
  - Delay line `sr[0..TAPS-1]` of DW bits each.
  - Coefficient RAM `coef[0..TAPS-1]` of CW bits each.
  - Accumulator `acc` of ACCW bits.
  - Tap index `idx` of clog2(TAPS) bits.
- Reset (`reset_p`=1 at an edge):
  - State goes to IDLE.
  - `ready`=1, `y`=0, `y_valid`=0.
  - `acc`=0, `idx`=0.
  - All `sr` entries = 0 and all `coef` entries = 0.
  - Reset overrides every other input on that edge.
- IDLE (`ready`=1):
  - On accept, shift the delay line: `sr[k]`←`sr[k-1]` for k≥1, and `sr[0]`←`x`.
  - On accept, also set `acc`←0, `idx`←0, `ready`←0, and go to MAC.
- MAC (`ready`=0):
  - Each cycle, `acc`←`acc` + sign-extended(`sr[idx]` × `coef[idx]`). The product is a full signed DW+CW-bit value.
  - `idx` increments each cycle.
  - When `idx`=TAPS-1, the last product is added on that edge and the state goes to OUT.
- OUT (one cycle):
  - Round: r = (`acc` + 2^(OSHIFT-1)) >>> OSHIFT, an arithmetic shift (round half up).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1] and write it to `y`.
  - `y_valid`←1 for exactly one cycle, `ready`←1, and go to IDLE.
- Accumulator overflow cannot occur under the ACCW constraint; no wrap handling is required.
- Coefficient write:
  - On an edge with `coef_we`=1, `ready`=1 and `coef_addr`<TAPS, `coef[coef_addr]`←`coef_wdata`.
  - Writes while `ready`=0, or with `coef_addr`≥TAPS, are ignored with no side effect.
  - A write and an accept on the same edge are both performed; the accepted sample is filtered with the new coefficient.
- `act` while `ready`=0 is ignored. The sample is not queued, and the upstream source must hold it.
- Reset mid-operation (MAC or OUT) aborts the computation. No `y_valid` is produced, and the delay line and coefficients are cleared.

## Timing
- Accept on edge N.
- MAC products are added on edges N+1 … N+TAPS.
- OUT executes on edge N+TAPS+1. After that edge, `y` is updated and `y_valid`=1 and `ready`=1 for that one cycle.
- The earliest next accept is edge N+TAPS+2. The throughput is one sample per TAPS+2 clocks; with the defaults this is 13.
- With `act` held at 1, accepts occur every TAPS+2 edges, and `y_valid` pulses with the same period.
- Each `y` is held until the next OUT; `y_valid` is 0 at all other times.
- `ready` is a registered output and does not depend combinationally on `act`.

## Test plan
- **Reset values:** assert `reset_p` for 2 cycles, then release → `ready`=1, `y`=0, `y_valid`=0. Then one sample with all coefficients 0 → `y`=0.
- **Impulse response:** with default parameters, load `coef[k]`=1000·(k+1). Send x=0x4000 followed by ten samples of 0 → successive `y` = 500, 1000, …, 5500, then 0 on the 12th sample.
- **Rounding:**
  - With `coef[0]`=1 and all other coefficients 0, x=0x4000 → `y`=1.
  - Then x=0x3FFF (delay line flushed) → `y`=0.
  - Then x=0xC000 → `y`=0 (half rounds up).
- **Saturation:**
  - All coefficients 0x7FFF and eleven samples of 0x7FFF → final `y`=0x7FFF.
  - All coefficients 0x7FFF and eleven samples of 0x8000 → final `y`=0x8000.
- **Handshake:** hold `act`=1 continuously → accepts every 13 edges. The `y_valid` period is 13 cycles, with each pulse exactly 1 cycle wide. `act` pulses during `ready`=0 do not change `y`.
- **Write and reset corner cases:**
  - `coef_we` during MAC, or with `coef_addr`=11 → the coefficient is unchanged, checked by a repeated impulse test.
  - A write on the same edge as an accept → the new coefficient is used.
  - `reset_p` at the 5th MAC edge → no `y_valid`; the next impulse with zero coefficients gives `y`=0.

Source files
------------

// File: rtl/fir_seq_param.sv
// Time-multiplexed signed FIR filter: one multiply-accumulate per clock across TAPS taps,
// run-time loadable coefficients, round-half-up and saturate to the sample width.
module fir_seq_param #(
    parameter int unsigned DW     = 16,
    parameter int unsigned CW     = 16,
    parameter int unsigned TAPS   = 11,
    parameter int unsigned AW     = 4,
    parameter int unsigned ACCW   = 40,
    parameter int unsigned OSHIFT = 15
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic [DW-1:0] x,
    input  logic          act,
    output logic          ready,
    output logic [DW-1:0] y,
    output logic          y_valid,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata
);
    localparam int unsigned IW = $clog2(TAPS);
    localparam int unsigned PW = DW + CW;

    localparam logic [IW-1:0]        LastIdx = IW'(TAPS - 1);
    localparam logic [AW:0]          TapsA   = (AW + 1)'(TAPS);
    localparam logic signed [ACCW:0] Half    = (ACCW + 1)'(1) << (OSHIFT - 1);
    localparam logic signed [ACCW:0] YMax    = {{(ACCW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACCW:0] YMin    = {{(ACCW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                  state_q, state_d;
    logic signed [DW-1:0]    sr_q   [TAPS];
    logic signed [DW-1:0]    sr_d   [TAPS];
    logic signed [CW-1:0]    coef_q [TAPS];
    logic signed [CW-1:0]    coef_d [TAPS];
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           y_q, y_d;
    logic                    y_valid_q, y_valid_d;

    logic                    accept;
    logic                    coef_wr;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW:0]    rnd;
    logic signed [ACCW:0]    shr;

    assign accept  = act && (state_q == StIdle);
    assign coef_wr = coef_we && (state_q == StIdle) && ({1'b0, coef_addr} < TapsA);
    assign prod    = sr_q[idx_q] * coef_q[idx_q];
    // One extra bit so adding the rounding constant can never wrap.
    assign rnd     = {acc_q[ACCW-1], acc_q} + Half;
    assign shr     = rnd >>> OSHIFT;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        coef_d    = coef_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        y_d       = y_q;
        y_valid_d = 1'b0;

        // Applied before the MAC starts, so a write alongside an accept is seen by that sample.
        if (coef_wr) begin
            coef_d[coef_addr[IW-1:0]] = coef_wdata;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    for (int unsigned k = 1; k < TAPS; k++) begin
                        sr_d[IW'(k)] = sr_q[IW'(k - 1)];
                    end
                    sr_d[0] = x;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + {{(ACCW - PW){prod[PW-1]}}, prod};
                idx_d = idx_q + IW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (shr > YMax) begin
                    y_d = YMax[DW-1:0];
                end else if (shr < YMin) begin
                    y_d = YMin[DW-1:0];
                end else begin
                    y_d = shr[DW-1:0];
                end
                y_valid_d = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= StIdle;
            sr_q      <= '{default: '0};
            coef_q    <= '{default: '0};
            acc_q     <= '0;
            idx_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            coef_q    <= coef_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign ready   = (state_q == StIdle);
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_seq_param.sv
// Self-checking bench for fir_seq_param: table vectors, directed corner sequences and
// randomized samples against an arithmetic reference model.
module tb_fir_seq_param;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int TAPS   = 11;
    localparam int AW     = 4;
    localparam int ACCW   = 40;
    localparam int OSHIFT = 15;
    localparam int NVEC   = 10;

    logic                 clk = 1'b0;
    logic                 reset_p;
    logic signed [DW-1:0] x;
    logic                 act;
    logic                 ready;
    logic signed [DW-1:0] y;
    logic                 y_valid;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;

    int n_vec = 0;
    int n_err = 0;

    int m_coef [TAPS];
    int m_sr   [TAPS];

    typedef struct packed {
        logic signed [CW-1:0] c0;
        logic signed [DW-1:0] xv;
        logic signed [DW-1:0] yexp;
    } vec_t;

    vec_t vecs [NVEC];

    int yv, lat, e, cnt, run, last_acc, last_v;
    int exp_q[$];

    fir_seq_param #(
        .DW    (DW),
        .CW    (CW),
        .TAPS  (TAPS),
        .AW    (AW),
        .ACCW  (ACCW),
        .OSHIFT(OSHIFT)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .x         (x),
        .act       (act),
        .ready     (ready),
        .y         (y),
        .y_valid   (y_valid),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_vec++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Reference model: plain dot product of the delay line and coefficients.
    function automatic void m_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_sr[i]   = 0;
        end
    endfunction

    function automatic void m_write(input int a, input int d);
        if (a >= 0 && a < TAPS) m_coef[a] = d;
    endfunction

    function automatic int m_accept(input int xv);
        longint s;
        for (int k = TAPS - 1; k > 0; k--) m_sr[k] = m_sr[k-1];
        m_sr[0] = xv;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(m_sr[k]) * longint'(m_coef[k]);
        s = (s + (longint'(1) <<< (OSHIFT - 1))) >>> OSHIFT;
        if (s > (longint'(1) <<< (DW - 1)) - 1) s = (longint'(1) <<< (DW - 1)) - 1;
        if (s < -(longint'(1) <<< (DW - 1))) s = -(longint'(1) <<< (DW - 1));
        return int'(s);
    endfunction

    task automatic do_reset();
        reset_p = 1'b1;
        act     = 1'b0;
        coef_we = 1'b0;
        tick();
        tick();
        reset_p = 1'b0;
        m_reset();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        if (!ready) check("ready_timeout", int'(ready), 1);
    endtask

    task automatic wait_valid(output int yo, output int lo);
        lo = 0;
        while (!y_valid && lo < 40) begin
            tick();
            lo++;
        end
        yo = int'(y);
    endtask

    task automatic write_coef(input int a, input int d);
        wait_ready();
        coef_we    = 1'b1;
        coef_addr  = AW'(a);
        coef_wdata = CW'(d);
        tick();
        coef_we = 1'b0;
        m_write(a, d);
    endtask

    task automatic send_chk(input string name, input int xv, input int expv);
        int yo, lo;
        wait_ready();
        x   = DW'(xv);
        act = 1'b1;
        tick();
        act = 1'b0;
        wait_valid(yo, lo);
        check({name, "_lat"}, lo, TAPS + 1);
        check(name, yo, expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        x = '0; coef_addr = '0; coef_wdata = '0;
        do_reset();
        check("rst_ready", int'(ready), 1);
        check("rst_y", int'(y), 0);
        check("rst_y_valid", int'(y_valid), 0);
        e = m_accept(16'h1234);
        send_chk("rst_zero_coef", 16'h1234, 0);

        // Single-tap rounding and saturation: {coef[0], x, expected y}.
        vecs[0] = '{16'sh0001, 16'sh4000, 16'sh0001};
        vecs[1] = '{16'sh0001, 16'sh3FFF, 16'sh0000};
        vecs[2] = '{16'sh0001, 16'shC000, 16'sh0000};
        vecs[3] = '{16'sh0001, 16'shC001, 16'sh0000};
        vecs[4] = '{16'sh0001, 16'shBFFF, 16'shFFFF};
        vecs[5] = '{16'shFFFF, 16'sh4000, 16'sh0000};
        vecs[6] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFE};
        vecs[7] = '{16'sh8000, 16'sh8000, 16'sh7FFF};
        vecs[8] = '{16'sh8000, 16'sh7FFF, 16'sh8001};
        vecs[9] = '{16'sh1234, 16'sh0000, 16'sh0000};
        for (int i = 0; i < NVEC; i++) begin
            write_coef(0, int'(vecs[i].c0));
            e = m_accept(int'(vecs[i].xv));
            send_chk($sformatf("vec%0d", i), int'(vecs[i].xv), int'(vecs[i].yexp));
        end

        // Impulse response.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 1000 * (k + 1));
        e = m_accept(16384);
        send_chk("imp0", 16384, 500);
        for (int i = 1; i < TAPS; i++) begin
            e = m_accept(0);
            send_chk($sformatf("imp%0d", i), 0, 500 * (i + 1));
        end
        e = m_accept(0);
        send_chk("imp_tail", 0, 0);

        // Saturation with full-scale coefficients.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        for (int i = 0; i < TAPS; i++) begin
            e = m_accept(32767);
            send_chk($sformatf("satp%0d", i), 32767, e);
        end
        check("sat_pos_final", int'(y), 32767);
        for (int i = 0; i < TAPS; i++) begin
            e = m_accept(-32768);
            send_chk($sformatf("satn%0d", i), -32768, e);
        end
        check("sat_neg_final", int'(y), -32768);

        // Continuous act: accept and y_valid periods, pulse width, values.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(8191)) - 4096);
        wait_ready();
        last_acc = -1; last_v = -1; run = 0;
        act = 1'b1;
        for (int c = 0; c < 70; c++) begin
            x = DW'($urandom);
            if (ready) begin
                if (last_acc >= 0) check("acc_period", c - last_acc, TAPS + 2);
                last_acc = c;
                exp_q.push_back(m_accept(int'(x)));
            end
            tick();
            if (y_valid) begin
                if (last_v >= 0 && run == 0) check("yv_period", c - last_v, TAPS + 2);
                if (run == 0) begin
                    last_v = c;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
                    check("hs_y", int'(y), e);
                end
                run++;
            end else if (run > 0) begin
                check("yv_width", run, 1);
                run = 0;
            end
        end
        act = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            if (y_valid) check("hs_drain_y", int'(y), exp_q.pop_front());
        end
        check("hs_drain_empty", exp_q.size(), 0);

        // act pulses while busy must be ignored.
        wait_ready();
        e = m_accept(12345);
        x = DW'(12345);
        act = 1'b1;
        tick();
        for (int c = 0; c < TAPS + 1; c++) begin
            act = (c == 2 || c == 6 || c == TAPS);
            x = DW'($urandom);
            tick();
        end
        act = 1'b0;
        check("busy_act_valid", int'(y_valid), 1);
        check("busy_act_y", int'(y), e);
        e = m_accept(-2222);
        send_chk("busy_act_next", -2222, e);

        // Writes while busy or out of range are dropped.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 1000 * (k + 1));
        write_coef(11, 32767);
        for (int i = 0; i < TAPS; i++) begin
            wait_ready();
            e = m_accept(0);
            x = '0;
            act = 1'b1;
            tick();
            act = 1'b0;
            tick();
            tick();
            coef_we = 1'b1; coef_addr = AW'(i); coef_wdata = 16'sh7FFF;
            tick();
            coef_we = 1'b0;
            wait_valid(yv, lat);
            check($sformatf("mac_wr_flush%0d", i), yv, e);
        end
        e = m_accept(16384);
        send_chk("rimp0", 16384, 500);
        for (int i = 1; i < TAPS; i++) begin
            e = m_accept(0);
            send_chk($sformatf("rimp%0d", i), 0, 500 * (i + 1));
        end
        e = m_accept(0);
        send_chk("rimp_tail", 0, 0);

        // Write on the same edge as an accept uses the new coefficient.
        wait_ready();
        coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'sd2000;
        x = 16'sh4000;
        act = 1'b1;
        m_write(0, 2000);
        e = m_accept(16384);
        tick();
        coef_we = 1'b0;
        act = 1'b0;
        wait_valid(yv, lat);
        check("same_edge_wr_y", yv, 1000);
        check("same_edge_wr_model", yv, e);

        // Reset on the 5th MAC edge aborts the computation.
        wait_ready();
        x = 16'sh4000;
        act = 1'b1;
        tick();
        act = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset_p = 1'b1;
        tick();
        reset_p = 1'b0;
        m_reset();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (y_valid) cnt++;
            tick();
        end
        check("abort_no_valid", cnt, 0);
        check("abort_ready", int'(ready), 1);
        check("abort_y", int'(y), 0);
        e = m_accept(16384);
        send_chk("abort_zero_coef", 16384, 0);

        // Randomized samples with occasional (possibly out-of-range) coefficient writes.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(8191)) - 4096);
        for (int i = 0; i < 30; i++) begin
            int xv;
            if (i % 5 == 0) write_coef(int'($urandom_range(15)), int'($urandom_range(8191)) - 4096);
            xv = int'($urandom_range(65535)) - 32768;
            e = m_accept(xv);
            send_chk($sformatf("rnd%0d", i), xv, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
